// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the router input queues and the switch allocator.
// The master side owns the input queues and the downstream credit view.
// The slave side is the allocator.
interface switch_allocator_if;
  logic [4:0]  req_valid_i;
  logic [2:0]  req_port_addr1_i;
  logic [2:0]  req_port_addr2_i;
  logic [2:0]  req_port_addr3_i;
  logic [2:0]  req_port_addr4_i;
  logic [2:0]  req_port_addr5_i;
  logic [4:0]  tail_i;
  logic [4:0]  out_ready_i;
  logic [4:0]  grant_o;
  logic [14:0] out_sel_o;
  logic [4:0]  out_valid_o;
  logic        err_o;

  modport master (
    output req_valid_i, req_port_addr1_i, req_port_addr2_i, req_port_addr3_i,
           req_port_addr4_i, req_port_addr5_i, tail_i, out_ready_i,
    input  grant_o, out_sel_o, out_valid_o, err_o
  );

  modport slave (
    input  req_valid_i, req_port_addr1_i, req_port_addr2_i, req_port_addr3_i,
           req_port_addr4_i, req_port_addr5_i, tail_i, out_ready_i,
    output grant_o, out_sel_o, out_valid_o, err_o
  );
endinterface

// File: rtl/switch_allocator.sv
// Packet-level (wormhole) switch allocator for a 5-port mesh router.
// Each output locks onto one input for a whole packet, and uses round-robin
// to pick the next owner after the current owner sends its tail flit.
// Allocation takes one cycle. Each released output then sits idle for one cycle.
module switch_allocator #(
  parameter int NPORTS = 5
) (
  input  logic clk,
  input  logic rst,
  switch_allocator_if.slave bus
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t             state_q [NPORTS];
  state_t             state_d [NPORTS];
  logic [2:0]         owner_q [NPORTS];
  logic [2:0]         owner_d [NPORTS];
  logic [2:0]         rr_q    [NPORTS];
  logic [2:0]         rr_d    [NPORTS];
  logic [NPORTS-1:0]  locked_q;
  logic [NPORTS-1:0]  locked_d;
  logic               err_q;
  logic               err_d;

  logic [2:0]         addr    [NPORTS];
  logic [NPORTS-1:0]  illegal;
  logic [NPORTS-1:0]  claimed;
  logic [NPORTS-1:0]  grant;
  logic [NPORTS-1:0]  out_valid;
  logic [3*NPORTS-1:0] out_sel;
  logic [2:0]         idx;

  // Adds an offset to a port index, modulo NPORTS, for the round-robin scan.
  function automatic logic [2:0] wrap_add(input logic [2:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NPORTS) sum = sum - NPORTS;
    return 3'(sum);
  endfunction

  assign addr[0] = bus.req_port_addr1_i;
  assign addr[1] = bus.req_port_addr2_i;
  assign addr[2] = bus.req_port_addr3_i;
  assign addr[3] = bus.req_port_addr4_i;
  assign addr[4] = bus.req_port_addr5_i;

  assign bus.grant_o     = grant;
  assign bus.out_valid_o = out_valid;
  assign bus.out_sel_o   = out_sel;
  assign bus.err_o       = err_q;

  // Flags illegal output addresses that come from unlocked heads. Locked inputs carry body flits, so their addresses are don't-care.
  always_comb begin
    illegal = '0;
    for (int i = 0; i < NPORTS; i++) begin
      illegal[i] = bus.req_valid_i[i] & ~locked_q[i] & (addr[i] > 3'd4);
    end
    err_d = err_q | (|illegal);
  end

  // Per-output FSM. An IDLE output scans from its rr pointer and claims the first unlocked input that asks for it. A LOCKED output forwards its owner's flits when credit is available and releases after the tail flit.
  always_comb begin
    locked_d  = locked_q;
    grant     = '0;
    out_valid = '0;
    out_sel   = '0;
    claimed   = '0;
    idx       = '0;
    for (int j = 0; j < NPORTS; j++) begin
      state_d[j] = state_q[j];
      owner_d[j] = owner_q[j];
      rr_d[j]    = rr_q[j];
      case (state_q[j])
        IDLE: begin
          for (int k = 0; k < NPORTS; k++) begin
            idx = wrap_add(rr_q[j], k);
            if (!claimed[j] && bus.req_valid_i[idx] && !locked_q[idx] &&
                addr[idx] == 3'(j)) begin
              claimed[j]    = 1'b1;
              owner_d[j]    = idx;
              state_d[j]    = LOCKED;
              locked_d[idx] = 1'b1;
            end
          end
        end
        LOCKED: begin
          out_sel[3*j +: 3]   = owner_q[j];
          out_valid[j]        = bus.req_valid_i[owner_q[j]] & bus.out_ready_i[j];
          grant[owner_q[j]]   = out_valid[j];
          if (out_valid[j] && bus.tail_i[owner_q[j]]) begin
            state_d[j]            = IDLE;
            locked_d[owner_q[j]]  = 1'b0;
            rr_d[j]               = wrap_add(owner_q[j], 1);
          end
        end
        default: state_d[j] = IDLE;
      endcase
    end
  end

  // State register. Reset drops every lock at once, so any partial packet is abandoned.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NPORTS; j++) begin
        state_q[j] <= IDLE;
        owner_q[j] <= '0;
        rr_q[j]    <= '0;
      end
      locked_q <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int j = 0; j < NPORTS; j++) begin
        state_q[j] <= state_d[j];
        owner_q[j] <= owner_d[j];
        rr_q[j]    <= rr_d[j];
      end
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for the switch allocator.
// Each record describes one clock cycle: the inputs driven during that cycle and the outputs expected in it.
module tb_switch_allocator;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  switch_allocator_if bus ();

  switch_allocator #(.NPORTS(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        r;
    logic [4:0]  valid;
    logic [14:0] addr;
    logic [4:0]  tail;
    logic [4:0]  ready;
    logic [4:0]  grant;
    logic [14:0] sel;
    logic [4:0]  oval;
    logic        err;
  } vec_t;

  int   tests_run    = 0;
  int   tests_failed = 0;
  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [4:0] valid, input logic [14:0] addr,
                              input logic [4:0] tail, input logic [4:0] ready,
                              input logic [4:0] grant, input logic [14:0] sel,
                              input logic [4:0] oval, input logic err);
    vec_t v;
    v.r = r; v.valid = valid; v.addr = addr; v.tail = tail; v.ready = ready;
    v.grant = grant; v.sel = sel; v.oval = oval; v.err = err;
    return v;
  endfunction

  // Waits for the next rising edge, then drives one cycle of inputs and leaves settle time before the outputs are checked.
  task automatic applyStimulus(input logic r, input logic [4:0] valid, input logic [14:0] addr,
                               input logic [4:0] tail, input logic [4:0] ready);
    @(posedge clk);
    #2;
    rst                  = r;
    bus.req_valid_i      = valid;
    bus.req_port_addr1_i = addr[2:0];
    bus.req_port_addr2_i = addr[5:3];
    bus.req_port_addr3_i = addr[8:6];
    bus.req_port_addr4_i = addr[11:9];
    bus.req_port_addr5_i = addr[14:12];
    bus.tail_i           = tail;
    bus.out_ready_i      = ready;
    #2;
  endtask

  task automatic compare_field(input string name, input logic [14:0] act, input logic [14:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [4:0] grant, input logic [14:0] sel,
                             input logic [4:0] oval, input logic err);
    compare_field({name, " grant"},     15'(bus.grant_o),     15'(grant));
    compare_field({name, " out_sel"},   bus.out_sel_o,        sel);
    compare_field({name, " out_valid"}, 15'(bus.out_valid_o), 15'(oval));
    compare_field({name, " err"},       15'(bus.err_o),       15'(err));
  endtask

  initial begin
    rst                  = 1'b1;
    bus.req_valid_i      = '0;
    bus.req_port_addr1_i = '0;
    bus.req_port_addr2_i = '0;
    bus.req_port_addr3_i = '0;
    bus.req_port_addr4_i = '0;
    bus.req_port_addr5_i = '0;
    bus.tail_i           = '0;
    bus.out_ready_i      = '0;
    repeat (2) @(posedge clk);

    // Reset state. After that, input 0 sends a 3-flit packet to output 2. The body-flit address 7 must be ignored while the input is locked.
    vecs.push_back(mk(0, 5'b00000, 15'h0000, 5'b00000, 5'b11111, 5'b00000, 15'h0000, 5'b00000, 0));
    vecs.push_back(mk(0, 5'b00001, 15'h0002, 5'b00000, 5'b11111, 5'b00000, 15'h0000, 5'b00000, 0));
    vecs.push_back(mk(0, 5'b00001, 15'h0007, 5'b00000, 5'b11111, 5'b00001, 15'h0000, 5'b00100, 0));
    vecs.push_back(mk(0, 5'b00001, 15'h0007, 5'b00000, 5'b11111, 5'b00001, 15'h0000, 5'b00100, 0));
    vecs.push_back(mk(0, 5'b00001, 15'h0007, 5'b00001, 5'b11111, 5'b00001, 15'h0000, 5'b00100, 0));
    vecs.push_back(mk(0, 5'b00000, 15'h0000, 5'b00000, 5'b11111, 5'b00000, 15'h0000, 5'b00000, 0));
    // Inputs 0, 1 and 3 send single-flit packets to output 4. The owners rotate 0, 1, 3, 0, with a bubble cycle before each grant.
    vecs.push_back(mk(0, 5'b01011, 15'h0824, 5'b11111, 5'b11111, 5'b00000, 15'h0000, 5'b00000, 0));
    vecs.push_back(mk(0, 5'b01011, 15'h0824, 5'b11111, 5'b11111, 5'b00001, 15'h0000, 5'b10000, 0));
    vecs.push_back(mk(0, 5'b01011, 15'h0824, 5'b11111, 5'b11111, 5'b00000, 15'h0000, 5'b00000, 0));
    vecs.push_back(mk(0, 5'b01011, 15'h0824, 5'b11111, 5'b11111, 5'b00010, 15'h1000, 5'b10000, 0));
    vecs.push_back(mk(0, 5'b01011, 15'h0824, 5'b11111, 5'b11111, 5'b00000, 15'h0000, 5'b00000, 0));
    vecs.push_back(mk(0, 5'b01011, 15'h0824, 5'b11111, 5'b11111, 5'b01000, 15'h3000, 5'b10000, 0));
    vecs.push_back(mk(0, 5'b01011, 15'h0824, 5'b11111, 5'b11111, 5'b00000, 15'h0000, 5'b00000, 0));
    vecs.push_back(mk(0, 5'b01011, 15'h0824, 5'b11111, 5'b11111, 5'b00001, 15'h0000, 5'b10000, 0));
    vecs.push_back(mk(0, 5'b00000, 15'h0000, 5'b00000, 5'b11111, 5'b00000, 15'h0000, 5'b00000, 0));
    // Input 0 locks output 3 and input 1 locks output 4 in the same cycle.
    vecs.push_back(mk(0, 5'b00011, 15'h0023, 5'b11111, 5'b11111, 5'b00000, 15'h0000, 5'b00000, 0));
    vecs.push_back(mk(0, 5'b00011, 15'h0023, 5'b11111, 5'b11111, 5'b00011, 15'h1000, 5'b11000, 0));
    vecs.push_back(mk(0, 5'b00000, 15'h0000, 5'b00000, 5'b11111, 5'b00000, 15'h0000, 5'b00000, 0));

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k].r, vecs[k].valid, vecs[k].addr, vecs[k].tail, vecs[k].ready);
      checkOutput($sformatf("vec%0d", k), vecs[k].grant, vecs[k].sel, vecs[k].oval, vecs[k].err);
    end

    // Input 2 is locked to output 0 when output 0 loses credit for three cycles. During the stall, input 3 also requests output 0 and must be ignored.
    applyStimulus(0, 5'b00100, 15'h0000, 5'b00000, 5'b11111);
    checkOutput("stall alloc", 5'b00000, 15'h0000, 5'b00000, 0);
    applyStimulus(0, 5'b00100, 15'h0000, 5'b00000, 5'b11111);
    checkOutput("stall first", 5'b00100, 15'h0002, 5'b00001, 0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 5'b01100, 15'h0040, 5'b00000, 5'b11110);
      checkOutput($sformatf("stall hold%0d", c), 5'b00000, 15'h0002, 5'b00000, 0);
    end
    applyStimulus(0, 5'b00100, 15'h0040, 5'b00100, 5'b11111);
    checkOutput("stall resume", 5'b00100, 15'h0002, 5'b00001, 0);
    applyStimulus(0, 5'b00000, 15'h0000, 5'b00000, 5'b11111);
    checkOutput("stall done", 5'b00000, 15'h0000, 5'b00000, 0);

    // Input 3 sends one flit on output 1, which moves rr1 to 4. Input 4 then wins against input 1 and is cut off by a reset in mid-packet.
    applyStimulus(0, 5'b01000, 15'h0200, 5'b11111, 5'b11111);
    checkOutput("rst alloc3", 5'b00000, 15'h0000, 5'b00000, 0);
    applyStimulus(0, 5'b01000, 15'h0200, 5'b11111, 5'b11111);
    checkOutput("rst grant3", 5'b01000, 15'h0018, 5'b00010, 0);
    applyStimulus(0, 5'b10010, 15'h1008, 5'b00000, 5'b11111);
    checkOutput("rst rr pick", 5'b00000, 15'h0000, 5'b00000, 0);
    applyStimulus(0, 5'b10010, 15'h1008, 5'b00000, 5'b11111);
    checkOutput("rst grant4", 5'b10000, 15'h0020, 5'b00010, 0);
    applyStimulus(1, 5'b10010, 15'h1008, 5'b00000, 5'b11111);
    applyStimulus(0, 5'b10000, 15'h1000, 5'b00000, 5'b11111);
    checkOutput("rst cleared", 5'b00000, 15'h0000, 5'b00000, 0);
    // After reset, input 4 relocks output 1 straight away. Its tail moves rr1 from 4 round to 0, so input 1 wins the next scan.
    applyStimulus(0, 5'b10000, 15'h1000, 5'b10000, 5'b11111);
    checkOutput("rst relock", 5'b10000, 15'h0020, 5'b00010, 0);
    applyStimulus(0, 5'b10010, 15'h1008, 5'b10010, 5'b11111);
    checkOutput("wrap bubble", 5'b00000, 15'h0000, 5'b00000, 0);
    applyStimulus(0, 5'b10010, 15'h1008, 5'b10010, 5'b11111);
    checkOutput("wrap pick1", 5'b00010, 15'h0008, 5'b00010, 0);
    applyStimulus(0, 5'b00000, 15'h0000, 5'b00000, 5'b11111);
    checkOutput("wrap done", 5'b00000, 15'h0000, 5'b00000, 0);

    // Input 4 requests illegal address 6. It is never granted, and err stays set until reset.
    applyStimulus(0, 5'b10000, 15'h6000, 5'b10000, 5'b11111);
    checkOutput("illegal req", 5'b00000, 15'h0000, 5'b00000, 0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 5'b10000, 15'h6000, 5'b10000, 5'b11111);
      checkOutput($sformatf("illegal hold%0d", c), 5'b00000, 15'h0000, 5'b00000, 1);
    end
    applyStimulus(0, 5'b00000, 15'h0000, 5'b00000, 5'b11111);
    checkOutput("illegal sticky", 5'b00000, 15'h0000, 5'b00000, 1);
    applyStimulus(1, 5'b00000, 15'h0000, 5'b00000, 5'b11111);
    applyStimulus(0, 5'b00000, 15'h0000, 5'b00000, 5'b11111);
    checkOutput("err cleared", 5'b00000, 15'h0000, 5'b00000, 0);

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
